sampler_ctrl: RTL and testbench

Parametrised capture controller that generates write-enable and address strobes for a sample RAM. It supports configurable depth, arming with a separate trigger input, decimation, single-shot or continuous re-arming, and abort. It sits between the control logic (start, trigger, mode) and the sample memory's write port, and signals capture completion to the readout logic (e.g. the RS-232 dump path).

---
 rtl/sampler_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sampler_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_ctrl.sv
// Capture controller producing write strobes and addresses for a sample RAM.
// Optional pre-trigger ring capture is enabled by defining SAMPLER_PRETRIG_EN.
module sampler_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 65536,
  parameter int DECIM_WIDTH = 8,
  parameter int PRETRIG     = 0
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  input  logic                   iStartSignal,
  input  logic                   iTrigger,
  input  logic                   iAbort,
  input  logic                   iContinuous,
  input  logic [DECIM_WIDTH-1:0] iDecim,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  output logic                   oArmed,
  output logic                   oBusy,
  output logic                   oFinished,
  output logic [ADDR_WIDTH-1:0]  oStartAddress
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
`ifdef SAMPLER_PRETRIG_EN
  localparam int PRE_KEPT = PRETRIG;
`else
  // Without the pre-trigger ring nothing is kept before the trigger.
  localparam int PRE_KEPT = 0 * PRETRIG;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_W      = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  PRE_W        = CNT_WIDTH'(PRE_KEPT);
  localparam logic [CNT_WIDTH-1:0]  WRITE_TARGET = CNT_WIDTH'(DEPTH - PRE_KEPT);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} stateT;

  stateT                  state, stateNext;
  logic [DECIM_WIDTH-1:0] decimLatched, decimLatchedNext;
  logic [DECIM_WIDTH-1:0] decimCount, decimCountNext, decimStep;
  logic                   contLatched, contLatchedNext;
  logic [ADDR_WIDTH-1:0]  addrPtr, addrPtrNext;
  logic [ADDR_WIDTH-1:0]  pendingStart, pendingStartNext;
  logic [CNT_WIDTH-1:0]   writeCount, writeCountNext;
  logic                   writeEnableNext, armedNext, busyNext, finishedNext;
  logic [ADDR_WIDTH-1:0]  addressNext, startAddressNext;
  logic                   sampleTick, preReady;
`ifdef SAMPLER_PRETRIG_EN
  logic [CNT_WIDTH-1:0]   preCount, preCountNext;
`endif

  function automatic logic [ADDR_WIDTH-1:0] incAddr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Oldest kept sample: step back PRE_KEPT slots around the ring.
  function automatic logic [ADDR_WIDTH-1:0] backOff(input logic [ADDR_WIDTH-1:0] a);
    logic [CNT_WIDTH-1:0] diff;
    diff = {1'b0, a} + DEPTH_W - PRE_W;
    if (diff >= DEPTH_W) diff = diff - DEPTH_W;
    return diff[ADDR_WIDTH-1:0];
  endfunction

  assign sampleTick = (decimCount == '0);
  assign decimStep  = (decimCount == decimLatched) ? '0 : decimCount + 1'b1;
`ifdef SAMPLER_PRETRIG_EN
  assign preReady = (preCount == PRE_W);
`else
  assign preReady = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    stateNext        = state;
    decimLatchedNext = decimLatched;
    decimCountNext   = decimCount;
    contLatchedNext  = contLatched;
    addrPtrNext      = addrPtr;
    pendingStartNext = pendingStart;
    writeCountNext   = writeCount;
    writeEnableNext  = 1'b0;
    addressNext      = oAddress;
    armedNext        = oArmed;
    busyNext         = oBusy;
    finishedNext     = 1'b0;
    startAddressNext = oStartAddress;
`ifdef SAMPLER_PRETRIG_EN
    preCountNext     = preCount;
`endif

    if (iAbort) begin
      stateNext = IDLE;
      armedNext = 1'b0;
      busyNext  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStartSignal) begin
            stateNext        = ARMED;
            decimLatchedNext = iDecim;
            contLatchedNext  = iContinuous;
            decimCountNext   = '0;
            addrPtrNext      = '0;
            armedNext        = 1'b1;
            busyNext         = 1'b1;
`ifdef SAMPLER_PRETRIG_EN
            preCountNext     = '0;
`endif
          end
        end

        ARMED: begin
          if (iTrigger && preReady) begin
            stateNext        = CAPTURE;
            decimCountNext   = '0;
            writeCountNext   = '0;
            pendingStartNext = backOff(addrPtr);
            armedNext        = 1'b0;
          end
`ifdef SAMPLER_PRETRIG_EN
          else begin
            decimCountNext = decimStep;
            if (sampleTick) begin
              writeEnableNext = 1'b1;
              addressNext     = addrPtr;
              addrPtrNext     = incAddr(addrPtr);
              if (preCount != PRE_W) preCountNext = preCount + 1'b1;
            end
          end
`endif
        end

        CAPTURE: begin
          if (writeCount == WRITE_TARGET) begin
            finishedNext     = 1'b1;
            startAddressNext = pendingStart;
            if (contLatched) begin
              stateNext      = ARMED;
              armedNext      = 1'b1;
              decimCountNext = '0;
`ifdef SAMPLER_PRETRIG_EN
              preCountNext   = '0;
`endif
            end else begin
              stateNext = IDLE;
              busyNext  = 1'b0;
            end
          end else begin
            decimCountNext = decimStep;
            if (sampleTick) begin
              writeEnableNext = 1'b1;
              addressNext     = addrPtr;
              addrPtrNext     = incAddr(addrPtr);
              writeCountNext  = writeCount + 1'b1;
            end
          end
        end

        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state         <= IDLE;
      decimLatched  <= '0;
      decimCount    <= '0;
      contLatched   <= 1'b0;
      addrPtr       <= '0;
      pendingStart  <= '0;
      writeCount    <= '0;
      oWriteEnable  <= 1'b0;
      oAddress      <= '0;
      oArmed        <= 1'b0;
      oBusy         <= 1'b0;
      oFinished     <= 1'b0;
      oStartAddress <= '0;
`ifdef SAMPLER_PRETRIG_EN
      preCount      <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state         <= stateNext;
      decimLatched  <= decimLatchedNext;
      decimCount    <= decimCountNext;
      contLatched   <= contLatchedNext;
      addrPtr       <= addrPtrNext;
      pendingStart  <= pendingStartNext;
      writeCount    <= writeCountNext;
      oWriteEnable  <= writeEnableNext;
      oAddress      <= addressNext;
      oArmed        <= armedNext;
      oBusy         <= busyNext;
      oFinished     <= finishedNext;
      oStartAddress <= startAddressNext;
`ifdef SAMPLER_PRETRIG_EN
      preCount      <= preCountNext;
`endif
    end
  end

endmodule

// File: tb/tb_sampler_ctrl.sv
// Directed self-checking bench for sampler_ctrl: a DEPTH=8 instance (PRETRIG=3)
// and a DEPTH=6 instance share stimulus; sel picks which one is observed.
module tb_sampler_ctrl;

  logic       iClock = 1'b0;
  logic       iReset_n = 1'b0;
  logic       iStartSignal = 1'b0;
  logic       iTrigger = 1'b0;
  logic       iAbort = 1'b0;
  logic       iContinuous = 1'b0;
  logic [7:0] iDecim = 8'd0;

  logic       we8, armed8, busy8, fin8, we6, armed6, busy6, fin6;
  logic [3:0] addr8, start8, addr6, start6;

  logic       sel = 1'b0;
  logic       obsWe, obsArmed, obsBusy, obsFin;
  logic [3:0] obsAddr, obsStart;

  int checks = 0;
  int failures = 0;

  always #5 iClock = ~iClock;

  sampler_ctrl #(.ADDR_WIDTH(4), .DEPTH(8), .DECIM_WIDTH(8), .PRETRIG(3)) dut8 (
    .iClock(iClock), .iReset_n(iReset_n), .iStartSignal(iStartSignal),
    .iTrigger(iTrigger), .iAbort(iAbort), .iContinuous(iContinuous), .iDecim(iDecim),
    .oWriteEnable(we8), .oAddress(addr8), .oArmed(armed8), .oBusy(busy8),
    .oFinished(fin8), .oStartAddress(start8)
  );

  sampler_ctrl #(.ADDR_WIDTH(4), .DEPTH(6), .DECIM_WIDTH(8), .PRETRIG(0)) dut6 (
    .iClock(iClock), .iReset_n(iReset_n), .iStartSignal(iStartSignal),
    .iTrigger(iTrigger), .iAbort(iAbort), .iContinuous(iContinuous), .iDecim(iDecim),
    .oWriteEnable(we6), .oAddress(addr6), .oArmed(armed6), .oBusy(busy6),
    .oFinished(fin6), .oStartAddress(start6)
  );

  assign obsWe    = sel ? we6    : we8;
  assign obsAddr  = sel ? addr6  : addr8;
  assign obsArmed = sel ? armed6 : armed8;
  assign obsBusy  = sel ? busy6  : busy8;
  assign obsFin   = sel ? fin6   : fin8;
  assign obsStart = sel ? start6 : start8;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic applyReset();
    iReset_n     = 1'b0;
    iStartSignal = 1'b0;
    iTrigger     = 1'b0;
    iAbort       = 1'b0;
    iContinuous  = 1'b0;
    iDecim       = 8'd0;
    step();
    step();
    iReset_n = 1'b1;
  endtask

  task automatic expectCycle(input string tag, input logic we, input logic [3:0] addr,
                             input logic armed, input logic busy, input logic fin);
    check({tag, ".we"}, obsWe, we);
    if (we) check({tag, ".addr"}, obsAddr, addr);
    check({tag, ".armed"}, obsArmed, armed);
    check({tag, ".busy"}, obsBusy, busy);
    check({tag, ".fin"}, obsFin, fin);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".we"}, obsWe, 0);
    check({tag, ".addr"}, obsAddr, 0);
    check({tag, ".armed"}, obsArmed, 0);
    check({tag, ".busy"}, obsBusy, 0);
    check({tag, ".fin"}, obsFin, 0);
    check({tag, ".start"}, obsStart, 0);
  endtask

  // Arm, then present the trigger so that it is sampled 'gap' edges after the arming edge.
  // iDecim/iContinuous are scrambled right after arming to show they are latched.
  task automatic armAndTrigger(input logic [7:0] decim, input logic cont, input int gap);
    iDecim       = decim;
    iContinuous  = cont;
    iStartSignal = 1'b1;
    step();
    iStartSignal = 1'b0;
    iDecim       = 8'd5;
    iContinuous  = ~cont;
    expectCycle("arm", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    repeat (gap - 1) step();
    iTrigger = 1'b1;
    step();
    iTrigger = 1'b0;
    expectCycle("trig", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Expect 'count' writes starting at firstAddr (wrapping at depth), then the finish cycle.
  task automatic expectCapture(input string tag, input int depth, input int count, input int decim,
                               input int firstAddr, input logic cont, input int expStart);
    int period = decim + 1;
    int span = (count - 1) * period + 1;
    for (int c = 1; c <= span; c++) begin
      step();
      expectCycle($sformatf("%s.c%0d", tag, c), ((c - 1) % period) == 0,
                  4'((firstAddr + (c - 1) / period) % depth), 1'b0, 1'b1, 1'b0);
    end
    step();
    expectCycle({tag, ".done"}, 1'b0, 4'd0, cont, cont, 1'b1);
    check({tag, ".start"}, obsStart, expStart);
  endtask

  initial begin
    sel = 1'b0;
    applyReset();
    checkAllZero("reset");

`ifdef SAMPLER_PRETRIG_EN
    // Ring writes while armed; early trigger ignored, later one accepted.
    iStartSignal = 1'b1;
    step();
    iStartSignal = 1'b0;
    expectCycle("pt.arm", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step();
    expectCycle("pt.w0", 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    step();
    expectCycle("pt.w1", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    iTrigger = 1'b1;
    step();
    iTrigger = 1'b0;
    expectCycle("pt.early", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    step();
    expectCycle("pt.w3", 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    step();
    expectCycle("pt.w4", 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
    iTrigger = 1'b1;
    step();
    iTrigger = 1'b0;
    expectCycle("pt.trig", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expectCapture("pt", 8, 5, 0, 5, 1'b0, 2);
    step();
    expectCycle("pt.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
`else
    // Single shot, iDecim=0, trigger three cycles after start.
    armAndTrigger(8'd0, 1'b0, 3);
    expectCapture("t1", 8, 8, 0, 0, 1'b0, 0);
    step();
    expectCycle("t1.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Decimation by 3.
    applyReset();
    armAndTrigger(8'd2, 1'b0, 1);
    expectCapture("t2", 8, 8, 2, 0, 1'b0, 0);

    // Continuous on DEPTH=6: two captures, pointer wraps 5 -> 0.
    sel = 1'b1;
    applyReset();
    armAndTrigger(8'd0, 1'b1, 2);
    expectCapture("t3a", 6, 6, 0, 0, 1'b1, 0);
    iTrigger = 1'b1;
    step();
    iTrigger = 1'b0;
    expectCycle("t3.retrig", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    expectCapture("t3b", 6, 6, 0, 0, 1'b1, 0);
    step();
    expectCycle("t3.rearmed", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    expectCycle("t3.abort", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Abort after three writes, then a normal capture, then reset mid-capture.
    sel = 1'b0;
    applyReset();
    armAndTrigger(8'd0, 1'b0, 2);
    for (int k = 0; k < 3; k++) begin
      step();
      expectCycle($sformatf("t4.w%0d", k), 1'b1, 4'(k), 1'b0, 1'b1, 1'b0);
    end
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    expectCycle("t4.abort", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      expectCycle($sformatf("t4.quiet%0d", k), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    check("t4.start", obsStart, 0);
    armAndTrigger(8'd0, 1'b0, 3);
    expectCapture("t4b", 8, 8, 0, 0, 1'b0, 0);
    armAndTrigger(8'd0, 1'b0, 2);
    step();
    step();
    expectCycle("t4.prerst", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    #2 iReset_n = 1'b0;
    #1 checkAllZero("t4.rst");
    step();
    iReset_n = 1'b1;

    // Trigger while idle, then start and trigger together.
    iTrigger = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      expectCycle($sformatf("t5.idle%0d", k), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    iStartSignal = 1'b1;
    step();
    iStartSignal = 1'b0;
    iTrigger     = 1'b0;
    expectCycle("t5.both", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      expectCycle($sformatf("t5.armed%0d", k), 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
